tbl_loader: RTL and testbench

- Write-side sequencer for the math lookup tables. It streams table words from a boot/microcode source into a table's write port (is_write, A = data word, B[53:46] = entry index).
- It walks entry indices sequentially with a valid/ready handshake on the input.
- It holds the table's read port off while loading and reports done or abort to the control unit.

---
 rtl/tbl_pkg.sv | 24 ++
 rtl/tbl_csum.sv | 33 +++
 rtl/tbl_loader.sv | 117 +++++++++++
 tb/tb_tbl_loader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tbl_pkg.sv
// Shared types and constants for the math lookup-table loader.
package tbl_pkg;

  localparam int TBL_DW          = 68;
  localparam int TBL_ENTRIES_MAX = 256;
  localparam int TBL_IDX_LO      = 46;
  localparam int TBL_IDX_HI      = 53;
  localparam int TBL_IDX_W       = TBL_IDX_HI - TBL_IDX_LO + 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH
  } state_t;

  // Places an entry index into the table's B operand; every other bit is zero.
  function automatic logic [TBL_DW-1:0] idx_word(input logic [TBL_IDX_W-1:0] idx);
    logic [TBL_DW-1:0] w;
    w = '0;
    w[TBL_IDX_HI:TBL_IDX_LO] = idx;
    return w;
  endfunction

endpackage

// File: rtl/tbl_csum.sv
// XOR checksum over the words written during one table load; the error flag
// is sticky until the next clear.
module tbl_csum
  import tbl_pkg::*;
#(
  parameter int DW = TBL_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] data,
  input  logic [DW-1:0] exp_csum,
  input  logic          cmp,
  output logic          err
);

  logic [DW-1:0] acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      err <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      err <= 1'b0;
    end else begin
      if (en) acc <= acc ^ data;
      if (cmp && (acc != exp_csum)) err <= 1'b1;
    end
  end

endmodule

// File: rtl/tbl_loader.sv
// Write-side sequencer that streams source words into a lookup table and locks
// out table reads while loading. Optional checksum: define TBL_LOADER_CSUM_EN.
module tbl_loader
  import tbl_pkg::*;
#(
  parameter int ENTRIES = TBL_ENTRIES_MAX,
  parameter int DW      = TBL_DW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DW-1:0]     in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     exp_csum,
  output logic [DW-1:0]     tbl_A,
  output logic [TBL_DW-1:0] tbl_B,
  output logic              tbl_is_write,
  output logic              tbl_is_read,
  input  logic              lookup_req,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              csum_err
);

  localparam logic [TBL_IDX_W-1:0] LAST_IDX = TBL_IDX_W'(ENTRIES - 1);

  state_t               state_q, state_d;
  logic [TBL_IDX_W-1:0] idx_q, idx_d;
  logic [TBL_IDX_W-1:0] wr_idx_q;
  logic                 accept;

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    accept   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      LOAD: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        // A beat presented together with abort is dropped, not written.
        accept   = in_valid & ~abort;
        if (abort) begin
          state_d = IDLE;
        end else if (in_valid) begin
          if (idx_q == LAST_IDX) state_d = FLUSH;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      FLUSH: begin
        busy    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      wr_idx_q     <= '0;
      tbl_A        <= '0;
      tbl_is_write <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      tbl_is_write <= accept;
      done         <= (state_q == FLUSH);
      aborted      <= (state_q == LOAD) && abort;
      if (accept) begin
        tbl_A    <= in_data;
        wr_idx_q <= idx_q;
      end
    end
  end

  assign tbl_B       = idx_word(wr_idx_q);
  // Combinational gate: a read can never land on the same cycle as a load write.
  assign tbl_is_read = lookup_req & ~busy;

`ifdef TBL_LOADER_CSUM_EN
  tbl_csum #(
    .DW(DW)
  ) u_csum (
    .clk     (clk),
    .rst     (rst),
    .clr     ((state_q == IDLE) && start),
    .en      (accept),
    .data    (in_data),
    .exp_csum(exp_csum),
    .cmp     (state_q == FLUSH),
    .err     (csum_err)
  );
`else
  logic unused_csum;
  assign unused_csum = ^exp_csum;
  assign csum_err    = 1'b0;
`endif

endmodule

// File: tb/tb_tbl_loader.sv
// Self-checking bench for tbl_loader: cycle model plus write scoreboard.
module tb_tbl_loader;
  import tbl_pkg::*;

  localparam int ENTRIES = 4;
  localparam int W       = TBL_DW;

  logic         clk, rst, start, abort, in_valid, in_ready, lookup_req;
  logic [W-1:0] in_data, exp_csum, tbl_A, tbl_B;
  logic         tbl_is_write, tbl_is_read, busy, done, aborted, csum_err;

  tbl_loader #(.ENTRIES(ENTRIES), .DW(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .exp_csum    (exp_csum),
    .tbl_A       (tbl_A),
    .tbl_B       (tbl_B),
    .tbl_is_write(tbl_is_write),
    .tbl_is_read (tbl_is_read),
    .lookup_req  (lookup_req),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .csum_err    (csum_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0]   idx;
    logic [W-1:0] data;
  } wr_t;
  wr_t sb[$];

  // Reference model state
  state_t       m_state;
  logic [7:0]   m_idx;
  logic [W-1:0] m_acc;
  logic         m_wr, m_done, m_aborted, m_err;
  logic         last_acc;
  int           cyc = 0, last_acc_cyc = -100;
  int           n_writes = 0, n_done = 0, n_aborted = 0;
  logic [W-1:0] words[16];

  task automatic model_reset();
    m_state = IDLE; m_idx = '0; m_acc = '0;
    m_wr = 1'b0; m_done = 1'b0; m_aborted = 1'b0; m_err = 1'b0;
    last_acc = 1'b0;
    sb.delete();
  endtask

  // Checks outputs at the falling edge, then advances the model across the
  // next rising edge; returns at posedge+1 ready for new stimulus.
  task automatic cycle();
    state_t       st_n;
    logic [7:0]   idx_n;
    logic [W-1:0] acc_n, exp_b;
    logic         err_n, acc;
    wr_t          e;
    @(negedge clk);
    check("busy", W'(busy), W'(m_state != IDLE));
    check("in_ready", W'(in_ready), W'(m_state == LOAD));
    check("tbl_is_read", W'(tbl_is_read), W'(lookup_req && (m_state == IDLE)));
    check("tbl_is_write", W'(tbl_is_write), W'(m_wr));
    check("done", W'(done), W'(m_done));
    check("aborted", W'(aborted), W'(m_aborted));
    check("csum_err", W'(csum_err), W'(m_err));
    if (tbl_is_write) begin
      n_writes++;
      if (sb.size() == 0) begin
        check("sb_underflow", W'(tbl_is_write), W'(0));
      end else begin
        e = sb.pop_front();
        exp_b = '0;
        exp_b[53:46] = e.idx;
        check("tbl_A", tbl_A, e.data);
        check("tbl_B", tbl_B, exp_b);
      end
    end
    if (done) begin
      n_done++;
      check("done_latency", W'(cyc - last_acc_cyc), W'(2));
      check("read_after_done", W'(tbl_is_read), W'(lookup_req));
    end
    if (aborted) n_aborted++;

    acc   = (m_state == LOAD) && in_valid && !abort;
    st_n  = m_state;
    idx_n = m_idx;
    acc_n = m_acc;
    err_n = m_err;
    case (m_state)
      IDLE: if (start) begin
        st_n = LOAD; idx_n = '0; acc_n = '0; err_n = 1'b0;
      end
      LOAD: begin
        if (abort) st_n = IDLE;
        else if (acc) begin
          sb.push_back('{idx: m_idx, data: in_data});
          acc_n = m_acc ^ in_data;
          if (m_idx == 8'(ENTRIES - 1)) st_n = FLUSH;
          else                          idx_n = m_idx + 8'd1;
        end
      end
      default: begin
        st_n = IDLE;
`ifdef TBL_LOADER_CSUM_EN
        err_n = m_err | (m_acc != exp_csum);
`endif
      end
    endcase
    m_wr      = acc;
    m_done    = (m_state == FLUSH);
    m_aborted = (m_state == LOAD) && abort;
    if (acc) last_acc_cyc = cyc;
    last_acc  = acc;
    m_state = st_n; m_idx = idx_n; m_acc = acc_n; m_err = err_n;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // mode 0: valid always; 1: valid on every third cycle; 2: random valid/start
  task automatic run(input int n, input int mode, input int abort_at, input bit do_start);
    int k = 0;
    for (int i = 0; i < n; i++) begin
      start = do_start && ((i == 0) || (mode == 2 && $urandom_range(0, 7) == 0));
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (i % 3 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      abort   = (i == abort_at);
      in_data = (k < 16) ? words[k] : W'({$urandom(), $urandom(), $urandom()});
      cycle();
      if (last_acc) k++;
    end
    start = 1'b0; abort = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0, a0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    in_data = '0; exp_csum = '0; lookup_req = 1'b0;
    model_reset();

    // Reset state
    @(posedge clk); #1;
    check("rst_tbl_A", tbl_A, '0);
    check("rst_tbl_B", tbl_B, '0);
    check("rst_is_write", W'(tbl_is_write), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_in_ready", W'(in_ready), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_aborted", W'(aborted), W'(0));
    check("rst_csum_err", W'(csum_err), W'(0));
    check("rst_is_read", W'(tbl_is_read), W'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Full load with lookups held high
    for (int i = 0; i < 16; i++) words[i] = W'(i + 1);
    lookup_req = 1'b1;
    w0 = n_writes; d0 = n_done;
    run(8, 0, -1, 1);
    check("full_writes", W'(n_writes - w0), W'(4));
    check("full_done", W'(n_done - d0), W'(1));
    lookup_req = 1'b0;

    // Source backpressure
    for (int i = 0; i < 16; i++) words[i] = W'(32'hA0 + i);
    w0 = n_writes; d0 = n_done;
    run(18, 1, -1, 1);
    check("bp_writes", W'(n_writes - w0), W'(4));
    check("bp_done", W'(n_done - d0), W'(1));

    // Abort after two accepts with a valid beat in the abort cycle
    w0 = n_writes; d0 = n_done; a0 = n_aborted;
    run(6, 0, 3, 1);
    check("abort_writes", W'(n_writes - w0), W'(2));
    check("abort_pulse", W'(n_aborted - a0), W'(1));
    check("abort_no_done", W'(n_done - d0), W'(0));
    for (int i = 0; i < 16; i++) words[i] = W'(32'h100 + i);
    w0 = n_writes; d0 = n_done;
    run(8, 0, -1, 1);
    check("reload_writes", W'(n_writes - w0), W'(4));
    check("reload_done", W'(n_done - d0), W'(1));

    // Asynchronous reset between clock edges mid-load
    d0 = n_done;
    run(3, 0, -1, 1);
    in_valid = 1'b1;
    #3 rst = 1'b1;
    #1;
    check("arst_is_write", W'(tbl_is_write), W'(0));
    check("arst_busy", W'(busy), W'(0));
    check("arst_in_ready", W'(in_ready), W'(0));
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    run(5, 0, -1, 0);
    check("arst_no_done", W'(n_done - d0), W'(0));

    // Random traffic, random data, occasional abort and stray start pulses
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) words[i] = W'({$urandom(), $urandom(), $urandom()});
      run(30, 2, ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 10)) : -1, 1);
    end

`ifdef TBL_LOADER_CSUM_EN
    for (int i = 0; i < 16; i++) words[i] = '0;
    words[0] = W'(8'hF0);
    words[1] = W'(8'h0F);
    exp_csum = W'(8'hFF);
    run(8, 0, -1, 1);
    check("csum_match", W'(csum_err), W'(0));
    exp_csum = W'(8'hFE);
    run(8, 0, -1, 1);
    check("csum_mismatch", W'(csum_err), W'(1));
    run(2, 0, -1, 1);
    check("csum_clear_on_start", W'(csum_err), W'(0));
    run(8, 0, -1, 0);
`endif

    check("sb_drained", W'(sb.size()), W'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
